alu_iter_divider: RTL
=====================

// Module: alu_iter_divider
// PURPOSE
//  Multi-cycle restoring divider for the ALU divide op (sel=2'b11).
//  Operand decode hands A (dividend) and B (divisor) over a valid/ready handshake.
//  Produces quotient, remainder and a divide-by-zero flag, replacing the single-cycle divide.
//  Result is held under a valid/ready handshake until the output mux consumes it.
// PARAMETERS
//  W  3  operand/result width in bits; legal range 2..8
// PORTS
//  clk          in   1  system clock; all state updates on rising edge
//  rst          in   1  synchronous active-high reset
//  in_valid     in   1  dividend/divisor valid this cycle
//  in_ready     out  1  divider can accept operands (high only in IDLE)
//  dividend     in   W  A operand, unsigned
//  divisor      in   W  B operand, unsigned
//  out_valid    out  1  quotient/remainder/div_by_zero valid
//  out_ready    in   1  downstream accepts result
//  quotient     out  W  unsigned A/B
//  remainder    out  W  unsigned A%B
//  div_by_zero  out  1  divisor was 0 for this result
//  busy         out  1  high in CALC or DONE
// BEHAVIOUR
//  Clocking/reset: one clock; reset is synchronous and active-high.
//  Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, busy=0.
//  Reset in any state (including mid-CALC or DONE with out_valid high):
//   - the in-flight operation is dropped; no result is presented.
//  in_ready = (state==IDLE); in_ready is 0 during reset cycle.
//  FSM states:
//   - IDLE: on in_valid&in_ready, latch operands.
//     - divisor!=0: go to CALC, step counter=W.
//     - divisor==0: go to DONE with quotient={W{1'b1}}, remainder=dividend, div_by_zero=1.
//   - CALC: one restoring step per cycle, MSB first.
//     - Shift {R,Q} left by 1, bringing in the next dividend bit; R is W+1 bits.
//     - If R>=D then R=R-D and Q[0]=1.
//     - Counter decrements each step; after step W, go to DONE.
//   - DONE: out_valid=1, outputs stable. On out_valid&out_ready, go to IDLE and set out_valid=0.
//  Latency, measured from the accept edge t0:
//   - out_valid rises after edge t0+W (normal) or t0+1 (divide by zero).
//   - Minimum accept-to-accept spacing is W+2 cycles; no accept in the same cycle as the output handshake.
//  in_valid outside IDLE: ignored; operands are not captured.
//  Operand inputs may change freely after the accept edge.
//  Backpressure: while out_valid&~out_ready, quotient/remainder/div_by_zero hold. out_valid never drops without a handshake.
//  div_by_zero is 0 for every nonzero divisor. It is cleared at the next accept.
//  Arithmetic: unsigned only; quotient*divisor+remainder==dividend and remainder<divisor whenever divisor!=0.
// TESTING
//  - W=3, 7/2, out_ready=1 -> out_valid 3 cycles after accept; q=3, r=1, dbz=0.
//  - 5/0 -> out_valid 1 cycle after accept; q=7, r=5, dbz=1.
//  - Edge operands: 0/3 -> q=0,r=0; 7/1 -> q=7,r=0; 3/7 -> q=0,r=3.
//  - 6/4, out_ready low 5 cycles:
//    - q=1, r=2 stay stable with out_valid high.
//    - in_ready=0 throughout; in_valid pulses with 7/7 are ignored.
//  - rst pulse during 2nd CALC step of 7/3 -> next cycle in_ready=1, out_valid=0; new 4/2 -> q=2, r=0.
//  - Exhaustive sweep of all 64 (A,B) pairs with random out_ready -> all results match reference model; no lost or duplicate results.

Source files
------------

// File: rtl/alu_iter_divider.sv
// ---------------------------------------------------------------------------
// alu_iter_divider
//
// Multi-cycle unsigned restoring divider for the ALU divide operation.
// Operands arrive over a valid/ready handshake. The quotient, remainder and a
// divide-by-zero flag are held under a second valid/ready handshake until the
// output mux takes them.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holds valid, and its data
// stable, until that edge. A consumer may raise or lower ready freely.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   in_valid     dividend/divisor are valid this cycle
//   in_ready     divider can accept operands (IDLE only, low while rst high)
//   dividend     A operand, unsigned, W bits
//   divisor      B operand, unsigned, W bits
//   out_valid    quotient/remainder/div_by_zero are valid
//   out_ready    downstream accepts the result
//   quotient     unsigned A/B (all ones when B==0)
//   remainder    unsigned A%B (A when B==0)
//   div_by_zero  divisor of the presented result was zero
//   busy         high in CALC or DONE
//
// Timing, counted from the accept edge t0:
//   normal       : W CALC steps on edges t0+1..t0+W, out_valid high after t0+W
//   divide by 0  : DONE is entered at t0, out_valid rises after t0+1
// ---------------------------------------------------------------------------
module alu_iter_divider #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero,
  output logic         busy
);

  // Step counter must hold the value W.
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Working registers for the restoring iteration.
  //   rem_acc : partial remainder. It is always < divisor after a step, so
  //             W bits are enough to store it; the shifted value needs W+1.
  //   quo_acc : starts as the dividend and is shifted out MSB first while the
  //             quotient bits are shifted in at the LSB end.
  logic [W-1:0]  rem_acc;
  logic [W-1:0]  quo_acc;
  logic [W-1:0]  div_reg;
  logic [CW-1:0] step_cnt;

  // One restoring step.
  logic [W:0]   rem_shift;
  logic         fits;
  logic [W-1:0] rem_sub;
  logic [W-1:0] rem_next;
  logic [W-1:0] quo_next;

  always_comb begin
    rem_shift = {rem_acc, quo_acc[W-1]};
    fits      = (rem_shift >= {1'b0, div_reg});
    // The difference is known to be < divisor whenever it is used, so a
    // modulo-2^W subtraction of the low bits gives the exact result.
    rem_sub   = rem_shift[W-1:0] - div_reg;
    rem_next  = fits ? rem_sub : rem_shift[W-1:0];
    quo_next  = {quo_acc[W-2:0], fits};
  end

  // Operands are only taken in IDLE and never while reset is asserted.
  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      rem_acc     <= '0;
      quo_acc     <= '0;
      div_reg     <= '0;
      step_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            div_reg     <= divisor;
            quo_acc     <= dividend;
            rem_acc     <= '0;
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
              // No iteration needed: the result is defined directly.
              quotient  <= '1;
              remainder <= dividend;
              state     <= DONE;
            end else begin
              step_cnt <= CW'(W);
              state    <= CALC;
            end
          end
        end

        CALC: begin
          rem_acc  <= rem_next;
          quo_acc  <= quo_next;
          step_cnt <= step_cnt - CW'(1);
          if (step_cnt == CW'(1)) begin
            // Last step: publish the result on the same edge.
            quotient  <= quo_next;
            remainder <= rem_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (!out_valid) begin
            // Divide-by-zero path arrives here with out_valid still low.
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
